uart_pkt_tx_arbiter: RTL and testbench
======================================

// Module: uart_pkt_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 24-bit UART packet transmitter (uart_top tx side)
//  among NREQ requesters. Latches the winner's word, drives uart_tx_req/idats, waits for
//  uart_txs_done, returns a per-requester done pulse, then enforces an idle gap before the next grant.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  DW          24   packet width, matches idats/odats
//  GAP_CYC     2    cycles uart_tx_req stays low between packets (>=1)
//  TIMEOUT_CYC 2^20 cycles allowed from request to uart_txs_done (only with timeout macro)
// PORTS
//  sys_clk        in   1        system clock
//  rst            in   1        synchronous reset, active-high
//  req            in   NREQ     per-requester level request; hold until grant pulse
//  req_data       in   NREQ*DW  requester i word at [i*DW +: DW]; sampled on grant cycle only
//  grant          out  NREQ     one-hot 1-cycle pulse: requester's word captured
//  done           out  NREQ     one-hot 1-cycle pulse: requester's packet fully sent
//  busy           out  1        high from grant through end of gap
//  uart_tx_req    out  1        to uart_top; level, held high until uart_txs_done
//  idats          out  DW       to uart_top; stable while uart_tx_req high
//  uart_txs_done  in   1        from uart_top; 1-cycle completion pulse
//  tx_timeout     out  1        1-cycle pulse on watchdog abort (tied 0 without macro)
// BEHAVIOUR
//  Reset: grant=0, done=0, busy=0, uart_tx_req=0, idats=0, tx_timeout=0, rr pointer=0, state IDLE.
//  FSM IDLE -> SEND -> GAP -> IDLE.
//  IDLE: if |req, pick first set bit at or after pointer (wrapping); next cycle grant[w]=1,
//   idats<=req_data[w], uart_tx_req=1, busy=1, state SEND. Latency req->uart_tx_req = 1 cycle.
//  SEND: uart_tx_req, idats, winner held; req changes ignored. On uart_txs_done:
//   uart_tx_req=0 and done[w]=1 next cycle, pointer<=(w+1)%NREQ, state GAP.
//  GAP: count GAP_CYC cycles, uart_tx_req low, busy high, then IDLE (new grant earliest
//   1 cycle after GAP ends). Back-to-back throughput: done -> next uart_tx_req >= GAP_CYC+1 cycles.
//  uart_txs_done in IDLE/GAP ignored (no done pulse, no state change).
//  Requester keeping req high after its done: rotates behind all other pending requesters.
//  Single requester alone: re-granted after every gap (no starvation, no lockout).
//  Reset mid-SEND: immediate return to reset values; aborted packet not reported; requester re-requests.
//  grant and done never both set in the same cycle; at most one bit of each set.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter starts on entering SEND; if TIMEOUT_CYC elapse without
//   uart_txs_done: uart_tx_req=0, tx_timeout pulse, no done pulse, pointer advances, state GAP.
//  Not defined: SEND waits indefinitely; tx_timeout constant 0; no counter logic.
// STRUCTURE
//  Package uart_arb_pkg: state enum (IDLE/SEND/GAP), DW default 24, index-width function clog2.
//  Sub-module rr_pick: combinational, inputs req/pointer, outputs one-hot winner + index + valid.
//  Top holds FSM, pointer, data/winner registers, gap and timeout counters.
// TESTING (bench loops uart_top tx to rx, checks odats against granted word)
//  Single req[1], data 0x002FE0 -> grant[1] 1 cycle later, odats=0x002FE0, done[1] once.
//  req=4'b1111 simultaneously, data 0x111111*i -> grant order 0,1,2,3, odats matches each.
//  req[2] held continuously with req[0] pulsed mid-SEND -> order 2,0,2; uart_tx_req low >=GAP_CYC.
//  Spurious uart_txs_done forced in IDLE -> no done, no state change.
//  rst asserted mid-SEND -> all outputs 0 next cycle; re-request req[3] completes normally.
//  UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=64, txs_done held 0 -> tx_timeout at cycle 64, no done, next req served.

Source files
------------

// File: rtl/uart_pkt_tx_arbiter_pkg.sv
// rtl/uart_pkt_tx_arbiter_pkg.sv - shared types and helpers for the UART packet TX arbiter
// Package uart_arb_pkg: FSM state enum, default packet width, index-width helper.
package uart_arb_pkg;

  localparam int DW_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Bits needed to index n items; never returns less than 1 so that
  // single-value counters still get a real register.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_pkt_tx_arbiter_rr_pick.sv
// rtl/uart_pkt_tx_arbiter_rr_pick.sv - combinational round-robin pick
// Module rr_pick: selects the first set request at or after the pointer, wrapping.
// Ports:
//   i_req    [NREQ]  request vector
//   i_ptr    [IW]    round-robin start position
//   o_onehot [NREQ]  one-hot winner (all zero when no request)
//   o_idx    [IW]    winner index
//   o_valid          any request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  always_comb begin
    int j;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_valid && i_req[j]) begin
        o_valid     = 1'b1;
        o_idx       = IW'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_pkt_tx_arbiter.sv
// rtl/uart_pkt_tx_arbiter.sv - round-robin arbiter for the shared 24-bit UART packet transmitter
// Optional feature macro: UART_ARB_TIMEOUT_EN (SEND watchdog, adds TIMEOUT_CYC parameter).
// Ports:
//   sys_clk, rst        clock, synchronous active-high reset
//   req [NREQ]          level requests, held until grant
//   req_data [NREQ*DW]  requester i word at [i*DW +: DW], sampled on grant
//   grant, done [NREQ]  one-hot single-cycle pulses
//   busy                grant through end of inter-packet gap
//   uart_tx_req, idats  to transmitter; idats stable while uart_tx_req high
//   uart_txs_done       transmitter completion pulse
//   tx_timeout          watchdog abort pulse (constant 0 without the macro)
module uart_pkt_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int GAP_CYC = 2
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1 << 20
`endif
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               uart_tx_req,
  output logic [DW-1:0]      idats,
  input  logic               uart_txs_done,
  output logic               tx_timeout
);

  localparam int IW = clog2(NREQ);
  localparam int GW = clog2(GAP_CYC + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   w_pick_idx;
  logic [IW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_pick_onehot;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            w_pick_valid;
  logic            w_take;
  logic            w_finish;
  logic            w_abort;
  logic            w_to_expire;
  logic [DW-1:0]   r_idats;
  logic [GW-1:0]   r_gap_cnt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_take      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // Completion wins over a watchdog expiry landing on the same cycle.
        if (uart_txs_done) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (w_to_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GW'(GAP_CYC - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The pointer moves past the winner so a requester that keeps asking
  // queues behind everyone else already pending.
  assign w_ptr_nxt = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_idats   <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_grant <= '0;
      r_done  <= '0;
      if (w_take) begin
        r_grant <= w_pick_onehot;
        r_win   <= w_pick_idx;
        r_idats <= req_data[int'(w_pick_idx)*DW +: DW];
      end
      if (w_finish || w_abort) begin
        r_ptr     <= w_ptr_nxt;
        r_gap_cnt <= '0;
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end
      if (w_finish) r_done <= NREQ'(1) << r_win;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYC);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  // Counts SEND cycles; held at zero elsewhere so it restarts on every entry.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      if (r_state != ST_SEND) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_to_expire = (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign tx_timeout  = r_timeout;
`else
  assign w_to_expire = 1'b0;
  assign tx_timeout  = 1'b0;
`endif

  assign grant       = r_grant;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign uart_tx_req = (r_state == ST_SEND);
  assign idats       = r_idats;

endmodule

// File: tb/tb_uart_pkt_tx_arbiter.sv
// tb/tb_uart_pkt_tx_arbiter.sv - self-checking bench for uart_pkt_tx_arbiter
module tb_uart_pkt_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 24;
  localparam int GAP  = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO   = 64;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               uart_tx_req;
  logic [DW-1:0]      idats;
  logic               uart_txs_done;
  logic               tx_timeout;

  always #5 clk = ~clk;

  uart_pkt_tx_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .GAP_CYC (GAP)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TO)
`endif
  ) dut (
    .sys_clk       (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .uart_tx_req   (uart_tx_req),
    .idats         (idats),
    .uart_txs_done (uart_txs_done),
    .tx_timeout    (tx_timeout)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Requester word queues; the front word is what each requester presents.
  logic [DW-1:0] q       [NREQ][$];
  logic [DW-1:0] exp_seq [NREQ][$];
  int            grant_log[$];
  int            gcyc_log[$];
  int            done_log[$];
  logic [DW-1:0] odats_log[$];

  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] data_last;
  logic               txs_last;
  logic               rst_last;

  // Reference model: who is sending, rotation start, first cycle a grant may appear.
  bit            m_send;
  int            m_win;
  int            m_ptr;
  int            m_ready;
  int            m_gcyc;
  logic [DW-1:0] m_word;

  bit rst_req   = 1'b0;
  bit resp_en   = 1'b1;
  bit spur_en   = 1'b0;
  bit force_txs = 1'b0;
  int resp_min  = 2;
  int resp_max  = 4;
  int resp_cnt  = 0;
  bit resp_fired = 1'b1;
  int low_run   = 0;
  int min_low   = 1000;
  bit seen_pkt  = 1'b0;
  int n_to_seen = 0;
  int to_cyc    = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int j = p; j < NREQ; j++) if (r[j]) return j;
    for (int j = 0; j < p; j++) if (r[j]) return j;
    return -1;
  endfunction

  task automatic push(input int i, input logic [DW-1:0] w);
    q[i].push_back(w);
    exp_seq[i].push_back(w);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gcyc_log.delete();
    done_log.delete();
    odats_log.delete();
    min_low = 1000;
  endtask

  task automatic step();
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] exp_d;
    logic            exp_to;
    int              w;
    // Drive inputs for the coming rising edge.
    rst = rst_req;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (q[i].size() > 0);
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
    end
    uart_txs_done = 1'b0;
    if (force_txs) begin
      uart_txs_done = 1'b1;
      force_txs     = 1'b0;
    end else if (!rst_req && resp_en && m_send && !resp_fired) begin
      if (resp_cnt == 0) begin
        uart_txs_done = 1'b1;
        resp_fired    = 1'b1;
        odats_log.push_back(idats);
      end else begin
        resp_cnt--;
      end
    end else if (!rst_req && spur_en && !m_send && $urandom_range(0, 7) == 0) begin
      uart_txs_done = 1'b1;
    end
    req_last  = req;
    data_last = req_data;
    txs_last  = uart_txs_done;
    rst_last  = rst;

    @(negedge clk);
    cyc++;

    if (rst_last) begin
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_req", uart_tx_req, 0);
      check("rst_idats", idats, 0);
      check("rst_timeout", tx_timeout, 0);
      m_send   = 1'b0;
      m_ptr    = 0;
      m_ready  = cyc + 1;
      seen_pkt = 1'b0;
      low_run  = 0;
    end else begin
      exp_g  = '0;
      exp_d  = '0;
      exp_to = 1'b0;
      w      = -1;
      if (m_send && txs_last) begin
        exp_d = NREQ'(1) << m_win;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (m_send && cyc == m_gcyc + TO) begin
        exp_to = 1'b1;
      end
`endif
      else if (!m_send && cyc >= m_ready && req_last != '0) begin
        w     = pick(req_last, m_ptr);
        exp_g = NREQ'(1) << w;
      end
      check("grant", grant, exp_g);
      check("done", done, exp_d);
      check("tx_timeout", tx_timeout, exp_to);
      if (tx_timeout) begin
        n_to_seen++;
        to_cyc = cyc;
      end
      if (exp_d != '0 || exp_to) begin
        m_send  = 1'b0;
        m_ptr   = (m_win + 1) % NREQ;
        m_ready = cyc + GAP + 1;
        if (exp_d != '0) done_log.push_back(m_win);
      end
      if (w >= 0) begin
        m_send = 1'b1;
        m_win  = w;
        m_gcyc = cyc;
        m_word = data_last[w*DW +: DW];
        grant_log.push_back(w);
        gcyc_log.push_back(cyc);
        void'(q[w].pop_front());
        resp_cnt   = $urandom_range(resp_max, resp_min);
        resp_fired = 1'b0;
      end
      check("busy", busy, (m_send || cyc < m_ready - 1));
      check("tx_req", uart_tx_req, m_send);
      if (m_send) check("idats", idats, m_word);
      if (!uart_tx_req) begin
        low_run++;
      end else begin
        if (seen_pkt && low_run > 0 && low_run < min_low) min_low = low_run;
        low_run  = 0;
        seen_pkt = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int b;
    b = budget;
    while (done_log.size() < n && b > 0) begin
      step();
      b--;
    end
    check("wait_done", done_log.size(), n);
  endtask

  task automatic wait_grant(input int n, input int budget);
    int b;
    b = budget;
    while (grant_log.size() < n && b > 0) begin
      step();
      b--;
    end
    check("wait_grant", grant_log.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin
      step();
      b--;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      exp_seq[i].delete();
    end
    rst_req = 1'b1;
    repeat (2) step();
    rst_req = 1'b0;
    clear_logs();
  endtask

  initial begin
    int            c0;
    int            i;
    int            n_words;
    logic [DW-1:0] wv;

    rst           = 1'b1;
    req           = '0;
    req_data      = '0;
    uart_txs_done = 1'b0;
    m_send        = 1'b0;
    m_win         = 0;
    m_ptr         = 0;
    m_ready       = 0;
    m_gcyc        = 0;
    m_word        = '0;

    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    clear_logs();

    // Single requester, grant one cycle after request.
    c0 = cyc;
    push(1, 24'h002FE0);
    wait_done(1, 100);
    repeat (6) step();
    check("t1_done_once", done_log.size(), 1);
    if (grant_log.size() >= 1) begin
      check("t1_winner", grant_log[0], 1);
      check("t1_latency", gcyc_log[0] - c0, 1);
    end
    if (odats_log.size() >= 1) check("t1_odats", odats_log[0], 24'h002FE0);

    // All four at once after reset: rotation 0,1,2,3.
    do_reset();
    for (int k = 0; k < NREQ; k++) push(k, DW'(24'h111111 * k));
    wait_done(4, 200);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) check("t2_order", grant_log[k], k);
      if (k < odats_log.size()) check("t2_odats", odats_log[k], DW'(24'h111111 * k));
    end

    // req[2] held, req[0] arrives mid-SEND: order 2,0,2 with full gaps.
    do_reset();
    push(2, 24'hA5A5A5);
    push(2, 24'h5A5A5A);
    wait_grant(1, 50);
    push(0, 24'hC0FFEE);
    wait_done(3, 200);
    if (grant_log.size() >= 3) begin
      check("t3_order0", grant_log[0], 2);
      check("t3_order1", grant_log[1], 0);
      check("t3_order2", grant_log[2], 2);
    end
    check("t3_gap", min_low, GAP + 1);

    // Spurious completion while idle is ignored, normal service follows.
    wait_idle(50);
    force_txs = 1'b1;
    step();
    step();
    check("t4_spur_done", done_log.size(), 3);
    check("t4_spur_busy", busy, 0);
    check("t4_spur_txreq", uart_tx_req, 0);
    for (int k = 0; k < 3; k++) push(1, DW'(24'h100 + k));
    wait_done(6, 200);
    for (int k = 3; k < 6; k++) if (k < done_log.size()) check("t4_alone", done_log[k], 1);

    // Reset in the middle of SEND aborts silently; re-request completes.
    do_reset();
    resp_min = 4;
    resp_max = 6;
    push(3, 24'hBEEF03);
    wait_grant(1, 50);
    step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      q[k].delete();
      exp_seq[k].delete();
    end
    repeat (8) step();
    check("t5_no_done", done_log.size(), 0);
    clear_logs();
    push(3, 24'hBEEF03);
    wait_done(1, 100);
    if (done_log.size() >= 1) check("t5_redo", done_log[0], 3);
    if (odats_log.size() >= 1) check("t5_odats", odats_log[0], 24'hBEEF03);

    // Randomised traffic with spurious completions and random response latency.
    do_reset();
    resp_min = 0;
    resp_max = 6;
    spur_en  = 1'b1;
    n_words  = 0;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        i = $urandom_range(0, NREQ - 1);
        if (q[i].size() < 3) begin
          wv = DW'($urandom);
          push(i, wv);
          n_words++;
        end
      end
      step();
    end
    wait_done(n_words, 3000);
    spur_en = 1'b0;
    for (int k = 0; k < done_log.size() && k < odats_log.size(); k++) begin
      i = done_log[k];
      if (exp_seq[i].size() > 0) check("rnd_odats", odats_log[k], exp_seq[i].pop_front());
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never answers: watchdog fires, next request still served.
    do_reset();
    resp_en   = 1'b0;
    n_to_seen = 0;
    push(1, 24'h123456);
    c0 = 0;
    while (n_to_seen == 0 && c0 < 200) begin
      step();
      c0++;
    end
    check("to_fired", n_to_seen, 1);
    if (gcyc_log.size() >= 1) check("to_cycles", to_cyc - gcyc_log[0], TO);
    check("to_no_done", done_log.size(), 0);
    resp_en = 1'b1;
    push(2, 24'h654321);
    wait_done(1, 100);
    if (done_log.size() >= 1) check("to_next", done_log[0], 2);
`endif

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
